// File: rtl/hamming_frame_rx.sv
// Serial receive framer ahead of the Hamming(7,4) dual-nibble decoder.
// Hunts for a sync word, then packs every 14 received bits into one codeword
// and strobes it to the decoder. A frame ends after WORDS_PER_FRAME codewords.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_HUNT    | shifting bits through sync_sr looking for SYNC_WORD
// ST_PAYLOAD | assembling 14-bit codewords; locked_o high
module hamming_frame_rx #(
   parameter int                  SYNC_LEN        = 8,
   parameter logic [SYNC_LEN-1:0] SYNC_WORD       = 8'hA5,
   parameter int                  WORDS_PER_FRAME = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        bit_in_i,
   input  logic        bit_valid_i,
   input  logic        flush_i,
   output logic [13:0] code_o,
   output logic        code_valid_o,
   output logic        sync_found_o,
   output logic        frame_done_o,
   output logic        locked_o
);

   localparam int WW = $clog2(WORDS_PER_FRAME + 1);
   localparam int FW = $clog2(SYNC_LEN + 1);

   typedef enum logic [0:0] {
      ST_HUNT    = 1'b0,
      ST_PAYLOAD = 1'b1
   } state_t;

   state_t              state_q;
   logic [SYNC_LEN-1:0] sync_sr_q;
   logic [FW-1:0]       fill_cnt_q;
   logic [12:0]         shift_sr_q;
   logic [3:0]          bit_cnt_q;
   logic [WW-1:0]       word_cnt_q;
   logic [13:0]         code_q;
   logic                code_valid_q;
   logic                sync_found_q;
   logic                frame_done_q;
   logic                locked_q;

   logic [SYNC_LEN-1:0] sync_sr_d;
   logic [13:0]         shift_sr_d;
   logic                match_d;
   logic                last_word_d;

   // Candidate shift values and decode of sync match / final word of frame.
   // fill_cnt_q guards against matching on bits older than the current hunt.
   always_comb begin
      sync_sr_d   = {sync_sr_q[SYNC_LEN-2:0], bit_in_i};
      shift_sr_d  = {shift_sr_q, bit_in_i};
      match_d     = (fill_cnt_q >= FW'(SYNC_LEN - 1)) && (sync_sr_d == SYNC_WORD);
      last_word_d = (word_cnt_q == WW'(WORDS_PER_FRAME - 1));
   end

   // Framer state machine with registered outputs; pulses default low each cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_HUNT;
         sync_sr_q    <= '0;
         fill_cnt_q   <= '0;
         shift_sr_q   <= '0;
         bit_cnt_q    <= '0;
         word_cnt_q   <= '0;
         code_q       <= '0;
         code_valid_q <= 1'b0;
         sync_found_q <= 1'b0;
         frame_done_q <= 1'b0;
         locked_q     <= 1'b0;
      end else begin
         code_valid_q <= 1'b0;
         sync_found_q <= 1'b0;
         frame_done_q <= 1'b0;
         if (flush_i) begin
            // Abort wins over any coincident match or word completion; code_q is kept.
            state_q    <= ST_HUNT;
            locked_q   <= 1'b0;
            sync_sr_q  <= '0;
            fill_cnt_q <= '0;
            shift_sr_q <= '0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
         end else if (bit_valid_i) begin
            case (state_q)
               ST_HUNT: begin
                  sync_sr_q <= sync_sr_d;
                  if (fill_cnt_q < FW'(SYNC_LEN)) begin
                     fill_cnt_q <= fill_cnt_q + FW'(1);
                  end
                  if (match_d) begin
                     state_q      <= ST_PAYLOAD;
                     sync_found_q <= 1'b1;
                     locked_q     <= 1'b1;
                     bit_cnt_q    <= '0;
                     word_cnt_q   <= '0;
                  end
               end
               ST_PAYLOAD: begin
                  shift_sr_q <= shift_sr_d[12:0];
                  if (bit_cnt_q == 4'd13) begin
                     code_q       <= shift_sr_d;
                     code_valid_q <= 1'b1;
                     bit_cnt_q    <= '0;
                     if (last_word_d) begin
                        // Frame complete: restart the hunt from an empty history.
                        frame_done_q <= 1'b1;
                        state_q      <= ST_HUNT;
                        locked_q     <= 1'b0;
                        word_cnt_q   <= '0;
                        sync_sr_q    <= '0;
                        fill_cnt_q   <= '0;
                     end else begin
                        word_cnt_q <= word_cnt_q + WW'(1);
                     end
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 4'd1;
                  end
               end
               default: begin
                  state_q  <= ST_HUNT;
                  locked_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign code_o       = code_q;
   assign code_valid_o = code_valid_q;
   assign sync_found_o = sync_found_q;
   assign frame_done_o = frame_done_q;
   assign locked_o     = locked_q;

endmodule

// File: tb/tb_hamming_frame_rx.sv
// Bench for hamming_frame_rx: directed scenarios plus a randomized stream,
// each checked against a bit-queue reference model of the framer.
module tb_hamming_frame_rx;

   localparam int         WPF = 2;
   localparam logic [7:0] SW  = 8'hA5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        bit_in = 1'b0;
   logic        bit_valid = 1'b0;
   logic        flush = 1'b0;
   logic [13:0] code;
   logic        cv, sf, fd, locked;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   hamming_frame_rx #(
      .SYNC_LEN        (8),
      .SYNC_WORD       (SW),
      .WORDS_PER_FRAME (WPF)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .bit_in_i     (bit_in),
      .bit_valid_i  (bit_valid),
      .flush_i      (flush),
      .code_o       (code),
      .code_valid_o (cv),
      .sync_found_o (sf),
      .frame_done_o (fd),
      .locked_o     (locked)
   );

   // Reference model: history of bits since entering hunt, payload bit queue.
   bit          m_hunt = 1'b1;
   bit          hist[$];
   bit          pay[$];
   int          m_words = 0;
   logic [13:0] m_code = '0;
   logic        m_cv = 1'b0, m_sf = 1'b0, m_fd = 1'b0, m_locked = 1'b0;
   logic [7:0]  m_win;

   always @(posedge clk) begin
      m_cv = 1'b0; m_sf = 1'b0; m_fd = 1'b0;
      if (rst) begin
         m_hunt = 1'b1; hist.delete(); pay.delete(); m_words = 0; m_code = '0;
      end else if (flush) begin
         m_hunt = 1'b1; hist.delete(); pay.delete(); m_words = 0;
      end else if (bit_valid) begin
         if (m_hunt) begin
            hist.push_back(bit_in);
            if (hist.size() > 8) void'(hist.pop_front());
            if (hist.size() == 8) begin
               m_win = '0;
               for (int i = 0; i < 8; i++) m_win = {m_win[6:0], hist[i]};
               if (m_win == SW) begin
                  m_hunt = 1'b0; m_sf = 1'b1; pay.delete(); m_words = 0;
               end
            end
         end else begin
            pay.push_back(bit_in);
            if (pay.size() == 14) begin
               m_code = '0;
               for (int i = 0; i < 14; i++) m_code = {m_code[12:0], pay[i]};
               pay.delete();
               m_cv = 1'b1;
               m_words++;
               if (m_words == WPF) begin
                  m_fd = 1'b1; m_hunt = 1'b1; hist.delete(); m_words = 0;
               end
            end
         end
      end
      m_locked = !m_hunt;
   end

   // Monitor: event counts for DUT and model, and cycles where they disagree.
   int cyc_bad = 0;
   int n_cv = 0, n_sf = 0, n_fd = 0, m_ncv = 0;

   always @(negedge clk) begin
      if ({code, cv, sf, fd, locked} !== {m_code, m_cv, m_sf, m_fd, m_locked}) begin
         cyc_bad++;
         if (cyc_bad <= 5)
            $display("divergence at %0t: dut code=%h cv=%b sf=%b fd=%b lk=%b model code=%h cv=%b sf=%b fd=%b lk=%b",
                     $time, code, cv, sf, fd, locked, m_code, m_cv, m_sf, m_fd, m_locked);
      end
      if (cv === 1'b1) n_cv++;
      if (sf === 1'b1) n_sf++;
      if (fd === 1'b1) n_fd++;
      if (m_cv) m_ncv++;
   end

   // One clock of stimulus; returns just after the following falling edge.
   task automatic step(input logic b, input logic v, input logic f);
      bit_in = b; bit_valid = v; flush = f;
      @(posedge clk);
      @(negedge clk);
      #1;
      bit_valid = 1'b0; flush = 1'b0;
   endtask

   task automatic send_bits(input logic [15:0] w, input int n, input int maxgap);
      logic [15:0] ww;
      ww = w;
      for (int i = n - 1; i >= 0; i--) begin
         int g;
         g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
         repeat (g) step(1'($urandom), 1'b0, 1'b0);
         step(ww[i], 1'b1, 1'b0);
      end
   endtask

   task automatic test_reset();
      int c0, bad0;
      bad0 = cyc_bad;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(1'($urandom), 1'($urandom), 1'b0);
         n_checks++;
         if ({code, cv, sf, fd, locked} !== 18'd0) begin
            n_fail++;
            $display("FAIL reset_outputs cycle %0d: got %h, expected 0", i, {code, cv, sf, fd, locked});
         end
      end
      rst = 1'b0;
      send_bits(16'(SW), 8, 0);
      send_bits(16'h0055, 7, 0);
      n_checks++;
      if (locked !== 1'b1) begin
         n_fail++; $display("FAIL reset_pre_locked: got %b, expected 1", locked);
      end
      rst = 1'b1;
      step(1'b1, 1'b1, 1'b0);
      rst = 1'b0;
      n_checks++;
      if (locked !== 1'b0) begin
         n_fail++; $display("FAIL reset_mid_locked: got %b, expected 0", locked);
      end
      c0 = n_cv;
      send_bits(16'h0000, 14, 0);
      n_checks++;
      if (n_cv !== c0) begin
         n_fail++; $display("FAIL reset_no_code_valid: got %0d pulses, expected 0", n_cv - c0);
      end
      n_checks++;
      if (cyc_bad !== bad0) begin
         n_fail++; $display("FAIL reset_model: got %0d divergent cycles, expected 0", cyc_bad - bad0);
      end
   endtask

   task automatic test_basic();
      int c0, bad0;
      logic [13:0] w;
      bad0 = cyc_bad; c0 = n_cv; w = 14'h2B4D;
      send_bits(16'(SW), 8, 0);
      n_checks++;
      if (sf !== 1'b1 || locked !== 1'b1) begin
         n_fail++; $display("FAIL basic_sync: got sf=%b locked=%b, expected 1 1", sf, locked);
      end
      send_bits(16'(w), 14, 0);
      n_checks++;
      if (cv !== 1'b1 || code !== w) begin
         n_fail++; $display("FAIL basic_code: got cv=%b code=%h, expected cv=1 code=%h", cv, code, w);
      end
      step(1'b0, 1'b0, 1'b0);
      n_checks++;
      if (cv !== 1'b0 || n_cv - c0 !== 1) begin
         n_fail++; $display("FAIL basic_pulse: got cv=%b count=%0d, expected 0 and 1", cv, n_cv - c0);
      end
      step(1'b0, 1'b0, 1'b1);
      n_checks++;
      if (cyc_bad !== bad0) begin
         n_fail++; $display("FAIL basic_model: got %0d divergent cycles, expected 0", cyc_bad - bad0);
      end
   endtask

   task automatic test_gaps();
      int c0, s0, bad0;
      for (int k = 0; k < 3; k++) begin
         bad0 = cyc_bad; c0 = n_cv; s0 = n_sf;
         send_bits(16'(SW), 8, 3);
         send_bits(16'h2B4D, 14, 3);
         repeat (3) step(1'($urandom), 1'b0, 1'b0);
         n_checks++;
         if (code !== 14'h2B4D || n_cv - c0 !== 1 || n_sf - s0 !== 1) begin
            n_fail++;
            $display("FAIL gaps_%0d: got code=%h cv=%0d sf=%0d, expected 2b4d 1 1", k, code, n_cv - c0, n_sf - s0);
         end
         step(1'b0, 1'b0, 1'b1);
         n_checks++;
         if (cyc_bad !== bad0) begin
            n_fail++; $display("FAIL gaps_model_%0d: got %0d divergent cycles, expected 0", k, cyc_bad - bad0);
         end
      end
   endtask

   task automatic test_frame_end();
      int c0, f0, bad0;
      bad0 = cyc_bad; c0 = n_cv; f0 = n_fd;
      send_bits(16'(SW), 8, 0);
      send_bits(16'h1234, 14, 0);
      n_checks++;
      if (fd !== 1'b0 || code !== 14'h1234) begin
         n_fail++; $display("FAIL frame_first: got fd=%b code=%h, expected 0 1234", fd, code);
      end
      send_bits(16'h0F0F, 14, 0);
      n_checks++;
      if (fd !== 1'b1 || cv !== 1'b1 || locked !== 1'b0) begin
         n_fail++; $display("FAIL frame_done: got fd=%b cv=%b locked=%b, expected 1 1 0", fd, cv, locked);
      end
      send_bits(16'h3FFF, 14, 0);
      n_checks++;
      if (n_cv - c0 !== 2 || n_fd - f0 !== 1 || code !== 14'h0F0F || locked !== 1'b0) begin
         n_fail++;
         $display("FAIL frame_after: got cv=%0d fd=%0d code=%h locked=%b, expected 2 1 0f0f 0",
                  n_cv - c0, n_fd - f0, code, locked);
      end
      step(1'b0, 1'b0, 1'b1);
      n_checks++;
      if (cyc_bad !== bad0) begin
         n_fail++; $display("FAIL frame_model: got %0d divergent cycles, expected 0", cyc_bad - bad0);
      end
   endtask

   task automatic test_hunt_align();
      int s0, bad0;
      logic [7:0] sw;
      bad0 = cyc_bad; s0 = n_sf; sw = SW;
      send_bits(16'h0005, 3, 0);
      send_bits(16'(SW), 8, 0);
      n_checks++;
      if (sf !== 1'b1 || n_sf - s0 !== 1) begin
         n_fail++; $display("FAIL align_sync: got sf=%b count=%0d, expected 1 1", sf, n_sf - s0);
      end
      send_bits(16'($urandom), 14, 0);
      send_bits(16'h0052, 14, 0);
      n_checks++;
      if (fd !== 1'b1) begin
         n_fail++; $display("FAIL align_frame_end: got fd=%b, expected 1", fd);
      end
      for (int i = 7; i >= 0; i--) begin
         step(sw[i], 1'b1, 1'b0);
         n_checks++;
         if (sf !== (i == 0)) begin
            n_fail++; $display("FAIL align_no_early bit %0d: got sf=%b, expected %b", 7 - i, sf, (i == 0));
         end
      end
      step(1'b0, 1'b0, 1'b1);
      n_checks++;
      if (cyc_bad !== bad0) begin
         n_fail++; $display("FAIL align_model: got %0d divergent cycles, expected 0", cyc_bad - bad0);
      end
   endtask

   task automatic test_flush();
      int c0, bad0;
      logic [13:0] w;
      bad0 = cyc_bad; w = 14'h2AAA;
      send_bits(16'(SW), 8, 0);
      send_bits(16'h1555, 14, 0);
      c0 = n_cv;
      send_bits(16'(w >> 1), 13, 0);
      step(w[0], 1'b1, 1'b1);
      n_checks++;
      if (cv !== 1'b0 || fd !== 1'b0 || code !== 14'h1555 || locked !== 1'b0 || n_cv !== c0) begin
         n_fail++;
         $display("FAIL flush_14th: got cv=%b fd=%b code=%h locked=%b, expected 0 0 1555 0", cv, fd, code, locked);
      end
      send_bits(16'(SW), 8, 0);
      send_bits(16'h0001, 14, 0);
      n_checks++;
      if (code !== 14'h0001 || cv !== 1'b1 || locked !== 1'b1) begin
         n_fail++; $display("FAIL flush_resync: got code=%h cv=%b locked=%b, expected 0001 1 1", code, cv, locked);
      end
      step(1'b0, 1'b0, 1'b1);
      n_checks++;
      if (cyc_bad !== bad0) begin
         n_fail++; $display("FAIL flush_model: got %0d divergent cycles, expected 0", cyc_bad - bad0);
      end
   endtask

   task automatic test_random();
      int c0, mc0, bad0;
      bad0 = cyc_bad; c0 = n_cv; mc0 = m_ncv;
      for (int k = 0; k < 80; k++) begin
         if ($urandom_range(3, 0) != 0) send_bits(16'(SW), 8, 2);
         for (int j = 0; j < int'($urandom_range(40, 0)); j++) begin
            case ($urandom_range(19, 0))
               0:       step(1'($urandom), 1'b1, 1'b1);
               1, 2:    step(1'($urandom), 1'b0, 1'b0);
               default: step(1'($urandom), 1'b1, 1'b0);
            endcase
         end
      end
      n_checks++;
      if (cyc_bad !== bad0) begin
         n_fail++; $display("FAIL random_model: got %0d divergent cycles, expected 0", cyc_bad - bad0);
      end
      n_checks++;
      if (n_cv - c0 !== m_ncv - mc0) begin
         n_fail++; $display("FAIL random_words: got %0d code_valid, expected %0d", n_cv - c0, m_ncv - mc0);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gaps();
      test_frame_end();
      test_hunt_align();
      test_flush();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
